// File: rtl/te_sched_pkg.sv
// Shared types and defaults for the tracking-engine FIFO scheduler.
package te_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REWIND,
    READ,
    WAIT_LAST,
    WAIT_DONE,
    SKIP
  } sched_state_t;

  localparam int unsigned DEF_CH_NUM         = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/te_sched_prio_enc.sv
// Lowest-set-bit encoder: picks the next pending channel in ascending order.
module te_sched_prio_enc
  import te_sched_pkg::*;
#(
  parameter int unsigned CH_NUM       = DEF_CH_NUM,
  parameter int unsigned CH_IDX_WIDTH = 3
) (
  input  logic [CH_NUM-1:0]       mask,
  output logic [CH_IDX_WIDTH-1:0] idx
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (mask[i] && !found) begin
        idx   = CH_IDX_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/te_fifo_sched.sv
// Round-robin scheduler sharing one tracking-engine FIFO block across correlator channels.
// Optional watchdog: define TE_SCHED_TIMEOUT_EN.
module te_fifo_sched
  import te_sched_pkg::*;
#(
  parameter int unsigned CH_NUM         = DEF_CH_NUM,
  parameter int unsigned CH_IDX_WIDTH   = 3,
  parameter int unsigned BLK_CNT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     te_enable,
  input  logic [CH_NUM-1:0]        channel_enable,
  input  logic                     fifo_ready,
  input  logic                     fifo_last_data,
  output logic                     fifo_read,
  output logic                     fifo_rewind,
  output logic                     fifo_skip,
  output logic                     ch_start,
  output logic [CH_IDX_WIDTH-1:0]  ch_index,
  input  logic                     ch_done,
  output logic                     round_done,
  output logic                     busy,
  output logic [BLK_CNT_WIDTH-1:0] block_count,
  output logic                     timeout_err
);

  sched_state_t            state, state_nxt;
  logic [CH_NUM-1:0]       pending;
  logic [CH_NUM-1:0]       remaining;
  logic [CH_IDX_WIDTH-1:0] next_idx;
  logic                    done_seen;
  logic                    chan_fin;
  logic                    abort;
  logic                    tmo;

  te_sched_prio_enc #(
    .CH_NUM      (CH_NUM),
    .CH_IDX_WIDTH(CH_IDX_WIDTH)
  ) u_prio_enc (
    .mask(pending),
    .idx (next_idx)
  );

  assign remaining = pending & ~(CH_NUM'(1) << ch_index);
  assign abort     = (state != IDLE) && !te_enable;

  always_comb begin
    state_nxt = state;
    chan_fin  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (te_enable && fifo_ready) state_nxt = (|channel_enable) ? REWIND : SKIP;
        REWIND: state_nxt = READ;
        READ:   state_nxt = WAIT_LAST;
        WAIT_LAST:
          if (tmo) begin
            chan_fin  = 1'b1;
            state_nxt = (|remaining) ? REWIND : SKIP;
          end else if (fifo_last_data) begin
            state_nxt = WAIT_DONE;
          end
        WAIT_DONE:
          if (ch_done || done_seen || tmo) begin
            chan_fin  = 1'b1;
            state_nxt = (|remaining) ? REWIND : SKIP;
          end
        SKIP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      pending     <= '0;
      ch_index    <= '0;
      done_seen   <= 1'b0;
      block_count <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        pending   <= '0;
        done_seen <= 1'b0;
      end else begin
        case (state)
          IDLE:      if (te_enable && fifo_ready) pending <= channel_enable;
          REWIND:    begin
            ch_index  <= next_idx;
            done_seen <= 1'b0;
          end
          // ch_done coinciding with the last sample must not be lost
          WAIT_LAST: if (fifo_last_data) done_seen <= ch_done;
          SKIP:      block_count <= block_count + 1'b1;
          default:   ;
        endcase
        if (chan_fin) begin
          pending   <= remaining;
          done_seen <= 1'b0;
        end
      end
    end
  end

  assign busy        = (state != IDLE);
  assign fifo_rewind = (state == REWIND);
  assign fifo_read   = (state == READ);
  assign ch_start    = (state == READ);
  assign fifo_skip   = (state == SKIP) && te_enable;
  assign round_done  = fifo_skip;

`ifdef TE_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] wd_cnt;
  logic          in_wait;
  logic          tmo_err;

  assign in_wait = (state == WAIT_LAST) || (state == WAIT_DONE);
  assign tmo     = in_wait && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wd_cnt  <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state_nxt != state) wd_cnt <= '0;
      else if (in_wait)       wd_cnt <= wd_cnt + 1'b1;
      if (tmo) tmo_err <= 1'b1;
    end
  end

  assign timeout_err = tmo_err;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo            = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_te_fifo_sched.sv
// Directed bench for te_fifo_sched: event-sequence model plus hand-computed timing checks.
module tb_te_fifo_sched;

`ifdef TE_SCHED_TIMEOUT_EN
  localparam int TMO = 32;
`else
  localparam int TMO = 4096;
`endif

  localparam logic [7:0] EV_REWIND = 8'b1000_0000;
  localparam logic [7:0] EV_SKIP   = 8'b0001_1000;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        te_enable = 1'b1;
  logic [7:0]  channel_enable = '0;
  logic        fifo_ready = 1'b0;
  logic        fifo_last_data = 1'b0;
  logic        fifo_read, fifo_rewind, fifo_skip, ch_start, round_done, busy, timeout_err;
  logic [2:0]  ch_index;
  logic        ch_done = 1'b0;
  logic [15:0] block_count;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] model_count = '0;

  te_fifo_sched #(
    .CH_NUM        (8),
    .CH_IDX_WIDTH  (3),
    .BLK_CNT_WIDTH (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .te_enable     (te_enable),
    .channel_enable(channel_enable),
    .fifo_ready    (fifo_ready),
    .fifo_last_data(fifo_last_data),
    .fifo_read     (fifo_read),
    .fifo_rewind   (fifo_rewind),
    .fifo_skip     (fifo_skip),
    .ch_start      (ch_start),
    .ch_index      (ch_index),
    .ch_done       (ch_done),
    .round_done    (round_done),
    .busy          (busy),
    .block_count   (block_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ev_read(input int ch);
    return 8'b0110_0000 | 8'(ch);
  endfunction

  // Model: a round serves enabled channels low to high, each as rewind then read; a full round ends in one skip.
  task automatic model_round(input logic [7:0] mask, input int limit, input bit with_skip);
    int served = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i] && served < limit) begin
        exp_q.push_back(EV_REWIND);
        exp_q.push_back(ev_read(i));
        served++;
      end
    end
    if (with_skip) exp_q.push_back(EV_SKIP);
  endtask

  // Compare process: every FIFO/channel pulse must be the next expected event; block_count follows retired skips.
  always @(negedge clk) begin
    logic [7:0] v, e;
    if (!rst_b) begin
      model_count = '0;
    end else begin
      check("block_count", 32'(block_count), 32'(model_count));
      v = {fifo_rewind, fifo_read, ch_start, fifo_skip, round_done,
           (fifo_read ? ch_index : 3'd0)};
      if (v != 8'd0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(v), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event", 32'(v), 32'(e));
          if (e == EV_SKIP) model_count = model_count + 16'd1;
        end
      end
    end
  end

  function automatic bit hit(input int which);
    return (which == 0) ? fifo_read : fifo_skip;
  endfunction

  // which: 0 = fifo_read, 1 = fifo_skip
  task automatic wait_for(input int which, input int budget, output int n);
    n = 0;
    while (!hit(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((which == 0) ? "wait_read" : "wait_skip", 32'(hit(which)), 32'd1);
  endtask

  task automatic serve(input int lat_last, input int lat_done);
    repeat (lat_last) @(negedge clk);
    fifo_last_data = 1'b1;
    if (lat_done == 0) ch_done = 1'b1;
    @(negedge clk);
    fifo_last_data = 1'b0;
    ch_done = 1'b0;
    if (lat_done > 0) begin
      repeat (lat_done - 1) @(negedge clk);
      ch_done = 1'b1;
      @(negedge clk);
      ch_done = 1'b0;
    end
  endtask

  task automatic pulse_ready(input logic [7:0] mask);
    channel_enable = mask;
    fifo_ready = 1'b1;
    @(negedge clk);
    fifo_ready = 1'b0;
    channel_enable = ~mask;
  endtask

  task automatic run_round(input logic [7:0] mask, input int lat_last, input int lat_done,
                           output int first_lat);
    int  n;
    bit  first = 1'b1;
    model_round(mask, 8, 1'b1);
    pulse_ready(mask);
    wait_for((mask == 8'd0) ? 1 : 0, 40, n);
    first_lat = 1 + n;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (!first) wait_for(0, 40, n);
        first = 1'b0;
        check("read_ch_index", 32'(ch_index), 32'(i));
        serve(lat_last, lat_done);
      end
    end
    if (mask != 8'd0) wait_for(1, 10, n);
    @(negedge clk);
    check("idle_after_round", 32'(busy), 32'd0);
    check("round_events_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {fifo_read, fifo_rewind, fifo_skip, ch_start, round_done, busy, timeout_err,
                 ch_index, block_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat, n;
    #12;
    check_all_zero("reset_outputs");
    @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);

    // Two channels, last 16 clks after read, done 2 clks later
    run_round(8'b0000_0101, 16, 2, lat);
    check("first_read_latency", 32'(lat), 32'd2);
    check("count_after_A", 32'(block_count), 32'd1);

    // Empty mask: skip straight from IDLE
    run_round(8'b0000_0000, 4, 1, lat);
    check("empty_skip_latency", 32'(lat), 32'd1);
    check("count_after_B", 32'(block_count), 32'd2);

    // Same-cycle last/done on channel 3
    model_round(8'b1000_1000, 8, 1'b1);
    pulse_ready(8'b1000_1000);
    wait_for(0, 40, n);
    check("C_ch_index", 32'(ch_index), 32'd3);
    serve(5, 0);
    check("C_wait_done_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("C_next_rewind", 32'(fifo_rewind), 32'd1);
    wait_for(0, 40, n);
    check("C_second_ch", 32'(ch_index), 32'd7);
    serve(5, 3);
    wait_for(1, 10, n);
    @(negedge clk);
    check("count_after_C", 32'(block_count), 32'd3);
    check("C_events_left", 32'(exp_q.size()), 32'd0);

    // Abort in WAIT_LAST of the second channel
    model_round(8'b0000_0110, 2, 1'b0);
    pulse_ready(8'b0000_0110);
    wait_for(0, 40, n);
    serve(4, 1);
    wait_for(0, 40, n);
    repeat (3) @(negedge clk);
    te_enable = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_skip", 32'(fifo_skip), 32'd0);
    check("abort_count", 32'(block_count), 32'd3);
    te_enable = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_events_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while in READ
    model_round(8'b0000_1100, 1, 1'b0);
    pulse_ready(8'b0000_1100);
    wait_for(0, 40, n);
    #2 rst_b = 1'b0;
    #1 check_all_zero("reset_mid_read");
    @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
    check("reset_events_left", 32'(exp_q.size()), 32'd0);
    run_round(8'b0000_1100, 6, 1, lat);
    check("post_reset_latency", 32'(lat), 32'd2);
    check("count_after_reset_round", 32'(block_count), 32'd1);

`ifdef TE_SCHED_TIMEOUT_EN
    // ch_done never arrives: watchdog retires the channel after 32 clks in WAIT_DONE
    model_round(8'b0000_0001, 8, 1'b1);
    pulse_ready(8'b0000_0001);
    wait_for(0, 40, n);
    repeat (4) @(negedge clk);
    fifo_last_data = 1'b1;
    @(negedge clk);
    fifo_last_data = 1'b0;
    check("tmo_not_yet", 32'(timeout_err), 32'd0);
    wait_for(1, 60, n);
    check("tmo_wait_cycles", 32'(n), 32'd32);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    @(negedge clk);
    check("tmo_count", 32'(block_count), 32'd2);
    check("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/te_fifo_sched.md
Name: te_fifo_sched

Overview:
Sequences one tracking-engine FIFO across up to CH_NUM correlator channels, so every active channel processes each sample block in turn.
- Waits for a full block (fifo_ready).
- For each enabled channel in ascending index order: rewinds the FIFO read pointer, issues a read, waits for the last sample, then waits for the channel to release the correlator.
- After all channels are served, skips the block and counts it.
- Sits between te_fifo and the correlator channel array.

Parameters:
CH_NUM, 8, number of correlator channels served.
CH_IDX_WIDTH, 3, width of the channel index; must satisfy 2^CH_IDX_WIDTH >= CH_NUM.
BLK_CNT_WIDTH, 16, width of the processed-block counter.
TIMEOUT_CYCLES, 4096, watchdog limit in clocks (used only with the optional feature).

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous reset, active low
te_enable  input  1  tracking engine enable; low aborts the current round
channel_enable  input  CH_NUM  per-channel enable, sampled at round start
fifo_ready  input  1  FIFO holds at least one block
fifo_last_data  input  1  last sample of the block output by the FIFO
fifo_read  output  1  one-cycle read command to the FIFO
fifo_rewind  output  1  one-cycle read-pointer rewind to the FIFO
fifo_skip  output  1  one-cycle block skip to the FIFO
ch_start  output  1  one-cycle pulse: channel ch_index begins a block
ch_index  output  CH_IDX_WIDTH  channel currently served
ch_done  input  1  served channel has finished accumulation
round_done  output  1  one-cycle pulse when a block is fully retired
busy  output  1  FSM is not IDLE
block_count  output  BLK_CNT_WIDTH  number of blocks retired, wraps
timeout_err  output  1  sticky watchdog error

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending mask 0.
- Reset is asynchronous active-low on all state. Reset mid-round returns to IDLE with no skip.
- FSM states: IDLE, REWIND, READ, WAIT_LAST, WAIT_DONE, SKIP.
- IDLE:
  - If te_enable & fifo_ready: latch pending = channel_enable.
  - If the latched mask is non-zero, go to REWIND.
  - If it is zero, go directly to SKIP, so the block is discarded and the FIFO cannot overflow.
- REWIND:
  - ch_index <= lowest set bit of pending (priority encoder).
  - fifo_rewind = 1 for exactly this cycle. Next state READ.
- READ:
  - fifo_read = 1 and ch_start = 1 for exactly this cycle. Next state WAIT_LAST.
- WAIT_LAST:
  - Hold until fifo_last_data = 1, then go to WAIT_DONE.
  - If ch_done arrives in the same cycle as fifo_last_data, record it and treat WAIT_DONE as already satisfied.
- WAIT_DONE:
  - Hold until ch_done (or the recorded done flag), then clear bit ch_index in pending.
  - If the remaining pending mask is non-zero, go to REWIND; otherwise go to SKIP.
- SKIP:
  - fifo_skip = 1 and round_done = 1 for one cycle; block_count += 1 (modulo 2^BLK_CNT_WIDTH).
  - Next state IDLE. fifo_ready is re-evaluated only from IDLE, so skips are never issued back to back.
- te_enable low in any non-IDLE state: return to IDLE next cycle, no fifo_skip, pending cleared, block_count unchanged.
- ch_done outside WAIT_LAST/WAIT_DONE is ignored.
- channel_enable changes during a round have no effect until the next round.
- busy = (state != IDLE).
- Minimum round latency per channel: 3 cycles plus FIFO block length. The fifo_read-to-fifo_last_data delay is set by the FIFO.

Optional Feature:
Macro: TE_SCHED_TIMEOUT_EN.
- With the macro: a counter runs in WAIT_LAST and WAIT_DONE and clears on state entry. When it reaches TIMEOUT_CYCLES-1:
  - timeout_err is set (sticky; cleared only by reset);
  - the channel is treated as done, and its pending bit is cleared;
  - the FSM proceeds as in WAIT_DONE.
- Without the macro: no counter; timeout_err is tied to 0; the FSM waits indefinitely.

Decomposition:
- Shared package te_sched_pkg holds:
  - state encoding typedef (6 states, 3 bits);
  - localparams for default CH_NUM and TIMEOUT_CYCLES.
- One natural sub-module: te_sched_prio_enc, a combinational lowest-set-bit encoder from CH_NUM mask to CH_IDX_WIDTH index.

Test Plan:
- channel_enable=8'b0000_0101, fifo_ready=1, last_data 16 clks after read, ch_done 2 clks later -> rewind/read for ch_index 0 then 2, one fifo_skip, round_done, block_count=1.
- channel_enable=0, fifo_ready=1 -> SKIP within 2 clks, no fifo_read or ch_start, block_count increments.
- fifo_last_data and ch_done in the same cycle for channel 3 -> no hang; next channel's REWIND follows 1 clk later.
- te_enable dropped during WAIT_LAST of the second channel -> IDLE next clk, no fifo_skip, busy=0, block_count unchanged.
- rst_b asserted mid-READ -> all outputs 0 immediately; after release, a fresh round starts from the lowest enabled channel.
- With TE_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32, ch_done never asserted -> timeout_err=1 after 32 clks in WAIT_DONE; scheduler advances and still issues fifo_skip.
